decoder_scan_sequencer: RTL and testbench



---
 rtl/decoder_scan_sequencer.sv | 98 +++++++++
 tb/tb_decoder_scan_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: round-robin select/enable driver for a one-hot decoder with blanking, dwell and channel mask.
// Optional `SCAN_ONESHOT_EN: stop in IDLE after each completed sweep instead of scanning continuously.
module decoder_scan_sequencer #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [2**SEL_W-1:0]   mask,
  output logic [SEL_W-1:0]      a,
  output logic                  enable,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int N  = 2**SEL_W;
  localparam int MX = DWELL > BLANK ? DWELL : BLANK;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_DWELL} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SEL_W-1:0] nxt, first;
  logic            all_masked, wrap;
  // Descending loops so the smallest offset / index wins; offset N lands back on a itself.
  always_comb begin
    nxt   = a;
    first = '0;
    for (int i = N; i >= 1; i--)
      if (!mask[SEL_W'(a + SEL_W'(i))]) nxt = SEL_W'(a + SEL_W'(i));
    for (int i = N - 1; i >= 0; i--)
      if (!mask[i]) first = SEL_W'(i);
  end
  assign all_masked = &mask;
  assign wrap       = nxt <= a;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      a          <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (stop) begin
        state  <= S_IDLE;
        cnt    <= '0;
        enable <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE:
            if (start && !all_masked) begin
              a      <= first;
              busy   <= 1'b1;
              cnt    <= '0;
              state  <= BLANK > 0 ? S_GAP : S_DWELL;
              enable <= BLANK == 0;
            end
          S_GAP:
            if (cnt == CW'(BLANK - 1)) begin
              cnt    <= '0;
              state  <= S_DWELL;
              enable <= 1'b1;
            end else cnt <= cnt + 1'b1;
          S_DWELL:
            if (cnt == CW'(DWELL - 1)) begin
              cnt <= '0;
              if (all_masked) begin
                state  <= S_IDLE;
                enable <= 1'b0;
                busy   <= 1'b0;
              end else begin
                a          <= nxt;
                frame_done <= wrap;
`ifdef SCAN_ONESHOT_EN
                if (wrap) begin
                  state  <= S_IDLE;
                  enable <= 1'b0;
                  busy   <= 1'b0;
                end else begin
                  state  <= BLANK > 0 ? S_GAP : S_DWELL;
                  enable <= BLANK == 0;
                end
`else
                state  <= BLANK > 0 ? S_GAP : S_DWELL;
                enable <= BLANK == 0;
`endif
              end
            end else cnt <= cnt + 1'b1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: table-driven scoreboard bench for decoder_scan_sequencer (default build).
module tb_decoder_scan_sequencer;
  localparam int DW = 4;
  localparam int BL = 1;
  logic clk = 0, rst, start, stop;
  logic [7:0] mask;
  logic [2:0] a;
  logic enable, busy, frame_done;
  logic start1;
  logic [7:0] mask1;
  logic [2:0] a1;
  logic en1, busy1, fd1;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  decoder_scan_sequencer #(.SEL_W(3), .DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
    .a(a), .enable(enable), .busy(busy), .frame_done(frame_done));
  decoder_scan_sequencer #(.SEL_W(3), .DWELL(1), .BLANK(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(1'b0), .mask(mask1),
    .a(a1), .enable(en1), .busy(busy1), .frame_done(fd1));
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  typedef struct {logic [2:0] a; logic fd;} visit_t;
  visit_t q[$];
  typedef struct {logic [7:0] mask; int visits; logic [2:0] first;} vec_t;
  vec_t vecs[5];
  // Monitor: one scoreboard pop per channel visit (rising enable), plus gap/dwell run lengths.
  logic mon_on = 0, prev_en = 0, fd_seen = 0;
  int lo_run = 0, hi_run = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      if (frame_done) fd_seen = 1;
      if (enable && !prev_en) begin
        if (q.size() > 0) begin
          visit_t e;
          e = q.pop_front();
          chk("visit_a", a, e.a);
          chk("visit_frame_done", fd_seen, e.fd);
          chk("gap_len", lo_run, BL);
        end
        lo_run = 0;
        fd_seen = 0;
      end
      if (!enable && prev_en) chk("dwell_len", hi_run, DW);
      if (enable) hi_run++;
      else begin
        hi_run = 0;
        if (busy) lo_run++;
      end
      prev_en = enable;
    end
  end
  function automatic logic [2:0] next_ch(logic [7:0] m, logic [2:0] cur);
    logic [2:0] c;
    c = cur;
    for (int j = 0; j < 8; j++) begin
      c = c + 3'd1;
      if (!m[c]) return c;
    end
    return cur;
  endfunction
  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_sel(logic [2:0] ch, string name);
    bit hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (a == ch && enable) hit = 1;
    end
    if (!hit) chk(name, 0, 1);
  endtask
  initial begin
    logic [2:0] cur, nx;
    int fd_cnt;
    vecs[0] = '{8'h00, 10, 3'd0};
    vecs[1] = '{8'hB6, 7, 3'd0};
    vecs[2] = '{8'hFE, 4, 3'd0};
    vecs[3] = '{8'h7F, 3, 3'd7};
    vecs[4] = '{8'h81, 8, 3'd1};
    rst = 1; start = 0; stop = 0; mask = 0; start1 = 0; mask1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a", a, 0);
    chk("rst_enable", enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    @(posedge clk); #1 rst = 0;
    mask = 8'hFF;
    @(posedge clk); #1 start = 1;
    repeat (3) @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("allmask_busy", busy, 0);
    chk("allmask_enable", enable, 0);
    foreach (vecs[v]) begin
      mask = vecs[v].mask;
      cur = vecs[v].first;
      q.push_back('{cur, 1'b0});
      for (int k = 1; k < vecs[v].visits; k++) begin
        nx = next_ch(mask, cur);
        q.push_back('{nx, nx <= cur});
        cur = nx;
      end
      prev_en = 0; lo_run = 0; hi_run = 0; fd_seen = 0;
      mon_on = 1;
      pulse_start();
      for (int c = 0; c < 400 && q.size() > 0; c++) @(posedge clk);
      if (q.size() > 0) begin
        chk("scoreboard_timeout", q.size(), 0);
        q.delete();
      end
      #1 mon_on = 0; stop = 1;
      @(posedge clk); #1 stop = 0;
      @(negedge clk);
      chk("stop_busy", busy, 0);
      chk("stop_enable", enable, 0);
    end
    mask = 8'h00;
    pulse_start();
    wait_sel(3'd3, "wait_ch3");
    @(negedge clk);
    stop = 1;
    @(negedge clk);
    chk("stop2_enable", enable, 0);
    chk("stop2_busy", busy, 0);
    chk("stop2_a", a, 3);
    chk("stop2_frame_done", frame_done, 0);
    stop = 0;
    pulse_start();
    @(negedge clk);
    chk("restart_a", a, 0);
    chk("restart_busy", busy, 1);
    chk("restart_gap_enable", enable, 0);
    wait_sel(3'd5, "wait_ch5");
    #2 rst = 1;
    #1;
    chk("async_rst_a", a, 0);
    chk("async_rst_enable", enable, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_frame_done", frame_done, 0);
    @(posedge clk); #1 rst = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    pulse_start();
    wait_sel(3'd2, "wait_ch2");
    mask = 8'hFF;
    fd_cnt = 0;
    for (int c = 0; c < 12 && busy; c++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    chk("maskall_busy", busy, 0);
    chk("maskall_enable", enable, 0);
    chk("maskall_a", a, 2);
    chk("maskall_no_fd", fd_cnt, 0);
    mask = 8'h00;
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("b0_a", a1, i % 8);
      chk("b0_enable", en1, 1);
      chk("b0_frame_done", fd1, (i > 0 && i % 8 == 0) ? 1 : 0);
    end
    chk("b0_busy", busy1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
